// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer arbiter: FSM state encoding and
// default timing constants.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_BYTE_DONE,
        ST_GAP
    } xfer_state_t;

    localparam int DEF_LEN_WIDTH    = 4;
    localparam int DEF_CS_SETUP_CYC = 4;
    localparam int DEF_CS_GAP_CYC   = 4;
    localparam int DEF_TIMEOUT_CYC  = 1024;
    localparam int DEF_CNT_WIDTH    = 11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a register
// remembering which requester owned the bus last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] grant
);

    logic last_was_1;

    // NOTE: state registers use non-blocking assignments and an async
    // active-low reset so every flop updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_1 <= 1'b1;
        end else if (update) begin
            last_was_1 <= owner;
        end
    end

    always_comb begin
        if (req == 2'b11) begin
            grant = last_was_1 ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-wide SPI master between two requesters: round-robin burst
// grant, chip-select framing, per-byte work enable, timeout abort.
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_GAP_CYC   = DEF_CS_GAP_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [2*LEN_WIDTH-1:0] len,
    input  logic [15:0]            tx_data,
    output logic [1:0]             tx_ready,
    output logic [7:0]             rx_data,
    output logic [1:0]             rx_valid,
    output logic [1:0]             done,
    output logic [1:0]             err,
    output logic [1:0]             grant,
    output logic                   om_work_en,
    output logic [7:0]             om_tx_data,
    input  logic [7:0]             im_rx_data,
    input  logic                   im_send_finish,
    input  logic                   im_receive_finish,
    output logic                   om_cs_n
);

    localparam logic [CNT_WIDTH-1:0] SETUP_LAST = CNT_WIDTH'(CS_SETUP_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(CS_GAP_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYC - 1);

    xfer_state_t          state, state_d;
    logic [1:0]           win;
    logic [1:0]           grant_q;
    logic [LEN_WIDTH-1:0] len_q, byte_cnt, win_len;
    logic [CNT_WIDTH-1:0] cnt;
    logic [7:0]           owner_tx;
    logic                 send_f, recv_f, send_now, recv_now;
    logic                 start, enter_xfer, tmo, last_byte, gap_end;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (gap_end),
        .owner  (grant_q[1]),
        .grant  (win)
    );

    assign win_len  = win[1] ? len[2*LEN_WIDTH-1:LEN_WIDTH] : len[LEN_WIDTH-1:0];
    assign owner_tx = grant_q[1] ? tx_data[15:8] : tx_data[7:0];
    assign send_now = send_f | im_send_finish;
    assign recv_now = recv_f | im_receive_finish;

    // Framing outputs decode straight from the state register, so an async
    // reset releases chip select and the master without waiting for a clock.
    assign om_cs_n    = !(state == ST_SETUP || state == ST_XFER || state == ST_BYTE_DONE);
    assign om_work_en = (state == ST_XFER);
    assign grant      = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state;
        start      = 1'b0;
        enter_xfer = 1'b0;
        tmo        = 1'b0;
        last_byte  = 1'b0;
        gap_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    start   = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    enter_xfer = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                // Byte completion wins over a timeout landing in the same cycle.
                if (send_now && recv_now) begin
                    state_d = ST_BYTE_DONE;
                end else if (cnt == TO_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_BYTE_DONE: begin
                if (byte_cnt == len_q) begin
                    last_byte = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    enter_xfer = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    gap_end = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            len_q      <= '0;
            byte_cnt   <= '0;
            cnt        <= '0;
            send_f     <= 1'b0;
            recv_f     <= 1'b0;
            om_tx_data <= '0;
            rx_data    <= '0;
            tx_ready   <= '0;
            rx_valid   <= '0;
            done       <= '0;
            err        <= '0;
        end else begin
            tx_ready <= '0;
            rx_valid <= '0;
            done     <= '0;
            err      <= '0;

            // One counter serves setup, timeout and gap; it restarts on every state change.
            if (state_d != state || state == ST_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (start) begin
                grant_q  <= win;
                len_q    <= win_len;
                byte_cnt <= '0;
            end
            if (gap_end) begin
                grant_q <= '0;
            end

            if (enter_xfer) begin
                om_tx_data <= owner_tx;
                tx_ready   <= grant_q;
                send_f     <= 1'b0;
                recv_f     <= 1'b0;
            end else if (state == ST_XFER) begin
                send_f <= send_now;
                recv_f <= recv_now;
            end

            if (state == ST_BYTE_DONE) begin
                rx_data  <= im_rx_data;
                rx_valid <= grant_q;
                if (!last_byte) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end

            if (last_byte) begin
                done <= grant_q;
            end
            if (tmo) begin
                err <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: vector table, hand-written corner
// sequences, and randomized bursts against a burst-level reference model.
module tb_spi_xfer_arbiter;

    localparam int LW    = 4;
    localparam int GAP_C = 4;
    localparam int TO_C  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0;
    logic [2*LW-1:0] len = '0;
    logic [15:0]   tx_data = '0;
    logic [1:0]    tx_ready, rx_valid, done, err, grant;
    logic [7:0]    rx_data, om_tx_data;
    logic          om_work_en, om_cs_n;
    logic [7:0]    im_rx_data = '0;
    logic          im_send_finish = 1'b0;
    logic          im_receive_finish = 1'b0;

    spi_xfer_arbiter #(
        .LEN_WIDTH    (LW),
        .CS_SETUP_CYC (4),
        .CS_GAP_CYC   (GAP_C),
        .TIMEOUT_CYC  (TO_C),
        .CNT_WIDTH    (11)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .len               (len),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .done              (done),
        .err               (err),
        .grant             (grant),
        .om_work_en        (om_work_en),
        .om_tx_data        (om_tx_data),
        .im_rx_data        (im_rx_data),
        .im_send_finish    (im_send_finish),
        .im_receive_finish (im_receive_finish),
        .om_cs_n           (om_cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Per-burst observations, cleared whenever chip select falls.
    int         cyc = 0;
    logic       prev_cs = 1'b1, prev_we = 1'b0;
    bit         seen_we;
    int         m_tx_cnt, m_rx_cnt, m_done_cnt, m_err_cnt, m_bad, m_xfer, m_bd, m_gap;
    logic [1:0] m_done_own, m_err_own;
    logic [7:0] m_tx_q[$];
    logic [7:0] m_rx_q[$];
    int         high_run = 0, min_hr = 1000;
    int         last_send_cyc = 0, last_bd_cyc = 0;

    // Requester byte generators and slave behaviour knobs.
    logic [7:0] base0 = '0, base1 = '0, idx0 = '0, idx1 = '0;
    bit         slv_hang = 1'b0;
    int         send_dly = 2, recv_dly = 3, en_cnt = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_cs && !om_cs_n) begin
            m_tx_cnt = 0; m_rx_cnt = 0; m_done_cnt = 0; m_err_cnt = 0; m_bad = 0;
            m_xfer = 0; m_bd = 0; m_gap = 0; seen_we = 1'b0;
            m_done_own = '0; m_err_own = '0;
            m_tx_q.delete(); m_rx_q.delete();
            if (high_run < min_hr) min_hr = high_run;
        end
        if (om_cs_n) high_run++; else high_run = 0;
        if (|tx_ready) begin
            m_tx_cnt++; m_tx_q.push_back(om_tx_data);
            if (tx_ready != grant) m_bad++;
        end
        if (|rx_valid) begin
            m_rx_cnt++; m_rx_q.push_back(rx_data);
            if (rx_valid != grant) m_bad++;
        end
        if (|done) begin
            m_done_cnt++; m_done_own |= done;
            if (!om_cs_n) m_bad++;
        end
        if (|err) begin
            m_err_cnt++; m_err_own |= err;
            if (!om_cs_n) m_bad++;
        end
        if (om_work_en) begin
            m_xfer++; seen_we = 1'b1;
            if (om_cs_n) m_bad++;
        end else if (!om_cs_n && seen_we) begin
            m_bd++;
        end
        if (!om_cs_n && !om_work_en && prev_we) last_bd_cyc = cyc;
        if (grant != 0 && om_cs_n) m_gap++;

        if (tx_ready[0]) idx0++;
        if (tx_ready[1]) idx1++;
        tx_data = {8'(base1 + idx1), 8'(base0 + idx0)};

        // Slave: answers each byte with tx+1 after configurable finish delays.
        im_send_finish    = 1'b0;
        im_receive_finish = 1'b0;
        if (om_work_en) begin
            en_cnt++;
            im_rx_data = om_tx_data + 8'd1;
            if (!slv_hang) begin
                if (en_cnt == send_dly) begin
                    im_send_finish = 1'b1;
                    last_send_cyc  = cyc;
                end
                if (en_cnt == recv_dly) im_receive_finish = 1'b1;
            end
        end else begin
            en_cnt = 0;
        end
        prev_cs = om_cs_n;
        prev_we = om_work_en;
    end

    task automatic run_burst(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                             input logic [7:0] b0, input logic [7:0] b1, input bit hold,
                             output logic [1:0] owner);
        int t;
        @(negedge clk);
        base0 = b0; base1 = b1; idx0 = '0; idx1 = '0;
        tx_data = {b1, b0};
        len = {l1, l0};
        req = r;
        t = 0;
        while (grant == 0 && t < 50) begin @(negedge clk); t++; end
        if (grant == 0) bound_fail("grant_wait");
        owner = grant;
        if (!hold) req = '0;
        t = 0;
        while (done == 0 && err == 0 && t < 3000) begin @(negedge clk); t++; end
        if (done == 0 && err == 0) bound_fail("burst_end_wait");
        t = 0;
        while (grant != 0 && t < 50) begin @(negedge clk); t++; end
        if (grant != 0) bound_fail("grant_release_wait");
    endtask

    typedef struct {
        logic [1:0] req;
        logic [3:0] l0, l1;
        logic [7:0] b0, b1;
        bit         hold;
        logic [1:0] exp_grant;
        int         exp_bytes;
        logic [7:0] exp_tx0, exp_rx_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0] own;
        int         t, eo, nb, model_last;
        logic [1:0] r;
        logic [3:0] l0, l1;
        logic [7:0] b0, b1, bsel;

        vecs[0] = '{2'b01, 4'd0, 4'd0,  8'h61, 8'h00, 1'b0, 2'b01, 1,  8'h61, 8'h62};
        vecs[1] = '{2'b10, 4'd0, 4'd2,  8'h00, 8'hA1, 1'b0, 2'b10, 3,  8'hA1, 8'hA4};
        vecs[2] = '{2'b10, 4'd0, 4'd15, 8'h00, 8'h10, 1'b0, 2'b10, 16, 8'h10, 8'h20};
        vecs[3] = '{2'b11, 4'd1, 4'd1,  8'h30, 8'h40, 1'b1, 2'b01, 2,  8'h30, 8'h32};
        vecs[4] = '{2'b11, 4'd1, 4'd1,  8'h30, 8'h40, 1'b1, 2'b10, 2,  8'h40, 8'h42};
        vecs[5] = '{2'b11, 4'd1, 4'd1,  8'h30, 8'h40, 1'b0, 2'b01, 2,  8'h30, 8'h32};

        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_work_en", om_work_en, 1'b0);
        check("rst_cs_n", om_cs_n, 1'b1);
        check("rst_om_tx_data", om_tx_data, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {tx_ready, rx_valid, done, err}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cs_n", om_cs_n, 1'b1);

        for (int i = 0; i < 6; i++) begin
            if (i == 3) min_hr = 1000;
            run_burst(vecs[i].req, vecs[i].l0, vecs[i].l1, vecs[i].b0, vecs[i].b1, vecs[i].hold, own);
            check($sformatf("v%0d_grant", i), own, vecs[i].exp_grant);
            check($sformatf("v%0d_tx_cnt", i), m_tx_cnt, vecs[i].exp_bytes);
            check($sformatf("v%0d_rx_cnt", i), m_rx_cnt, vecs[i].exp_bytes);
            check($sformatf("v%0d_done", i), {m_done_cnt[7:0], 6'd0, m_done_own}, {8'd1, 6'd0, vecs[i].exp_grant});
            check($sformatf("v%0d_err", i), m_err_cnt, 0);
            check($sformatf("v%0d_byte_gaps", i), m_bd, vecs[i].exp_bytes);
            check($sformatf("v%0d_gap_len", i), m_gap, GAP_C);
            check($sformatf("v%0d_tx0", i), (m_tx_q.size() > 0) ? m_tx_q[0] : 8'hxx, vecs[i].exp_tx0);
            check($sformatf("v%0d_rx_last", i),
                  (m_rx_q.size() > 0) ? m_rx_q[m_rx_q.size()-1] : 8'hxx, vecs[i].exp_rx_last);
            check($sformatf("v%0d_protocol", i), m_bad, 0);
        end
        check("cs_high_min_ge_gap", (min_hr >= GAP_C) ? 1 : 0, 1);

        // Finish ordering: receive five cycles before send, then simultaneous.
        recv_dly = 1; send_dly = 6;
        run_burst(2'b01, 4'd0, 4'd0, 8'h11, 8'h00, 1'b0, own);
        check("recv_first_bd_delay", last_bd_cyc - last_send_cyc, 1);
        check("recv_first_rx", (m_rx_q.size() > 0) ? m_rx_q[0] : 8'hxx, 8'h12);
        recv_dly = 3; send_dly = 3;
        run_burst(2'b01, 4'd0, 4'd0, 8'h21, 8'h00, 1'b0, own);
        check("same_cycle_bd_delay", last_bd_cyc - last_send_cyc, 1);
        recv_dly = 3; send_dly = 2;

        // Master never finishes: timeout abort, then the other requester wins.
        slv_hang = 1'b1;
        run_burst(2'b01, 4'd3, 4'd0, 8'h50, 8'h00, 1'b0, own);
        check("to_err", {m_err_cnt[7:0], 6'd0, m_err_own}, {8'd1, 8'h01});
        check("to_xfer_cycles", m_xfer, TO_C);
        check("to_no_rx_done", {m_rx_cnt[7:0], m_done_cnt[7:0]}, 16'h0000);
        check("to_tx_cnt", m_tx_cnt, 1);
        check("to_protocol", m_bad, 0);
        slv_hang = 1'b0;
        run_burst(2'b11, 4'd0, 4'd0, 8'h55, 8'h66, 1'b0, own);
        check("after_to_grant", own, 2'b10);
        check("after_to_done", m_done_cnt, 1);

        // Async reset in the middle of a 4-byte burst.
        @(negedge clk);
        base0 = 8'h70; idx0 = '0; tx_data = {8'h00, 8'h70};
        len = {4'd0, 4'd3}; req = 2'b01;
        t = 0;
        while (grant == 0 && t < 50) begin @(negedge clk); t++; end
        req = '0;
        t = 0;
        while (m_tx_cnt < 2 && t < 500) begin @(negedge clk); t++; end
        if (m_tx_cnt < 2) bound_fail("second_byte_wait");
        check("pre_rst_work_en", om_work_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_cs_work", {om_cs_n, om_work_en}, 2'b10);
        check("mid_rst_data", {om_tx_data, rx_data}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(2'b01, 4'd3, 4'd0, 8'h70, 8'h00, 1'b0, own);
        check("post_rst_grant", own, 2'b01);
        check("post_rst_bytes", {m_tx_cnt[7:0], m_rx_cnt[7:0]}, 16'h0404);
        check("post_rst_tx0", (m_tx_q.size() > 0) ? m_tx_q[0] : 8'hxx, 8'h70);
        check("post_rst_rx_last", (m_rx_q.size() > 0) ? m_rx_q[m_rx_q.size()-1] : 8'hxx, 8'h74);

        // Random bursts against the burst-level model.
        model_last = 0;
        for (int n = 0; n < 16; n++) begin
            r  = 2'($urandom_range(1, 3));
            l0 = 4'($urandom_range(0, 7));
            l1 = 4'($urandom_range(0, 7));
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            send_dly = $urandom_range(1, 5);
            recv_dly = $urandom_range(1, 5);
            eo = (r == 2'b11) ? 1 - model_last : ((r == 2'b10) ? 1 : 0);
            model_last = eo;
            nb   = (eo == 1) ? int'(l1) + 1 : int'(l0) + 1;
            bsel = (eo == 1) ? b1 : b0;
            run_burst(r, l0, l1, b0, b1, 1'b0, own);
            check($sformatf("rnd%0d_grant", n), own, (eo == 1) ? 2'b10 : 2'b01);
            check($sformatf("rnd%0d_counts", n), {m_tx_cnt[7:0], m_rx_cnt[7:0], m_done_cnt[7:0]},
                  {8'(nb), 8'(nb), 8'd1});
            for (int k = 0; k < nb; k++) begin
                check($sformatf("rnd%0d_tx%0d", n, k),
                      (k < m_tx_q.size()) ? m_tx_q[k] : 8'hxx, 8'(bsel + 8'(k)));
                check($sformatf("rnd%0d_rx%0d", n, k),
                      (k < m_rx_q.size()) ? m_rx_q[k] : 8'hxx, 8'(bsel + 8'(k) + 8'd1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Sequences and shares one SPI master byte engine (level-enabled, 8-bit, with send/receive finish pulses) between two requesters.
- Each requester asks for a burst of 1..2^LEN_WIDTH bytes. The block grants round-robin, drives chip-select and the master's work enable byte by byte, and returns received bytes.
- Sits between client logic and L1_spi_master_v2 in the SPI top level.

Parameters:
- LEN_WIDTH, 4, width of burst length field; burst bytes = len+1.
- CS_SETUP_CYC, 4, clk cycles cs_n low before first byte enable (must be >=1).
- CS_GAP_CYC, 4, clk cycles cs_n high after a burst before next grant (must be >=1).
- TIMEOUT_CYC, 1024, max clk cycles in XFER waiting for byte completion.
- CNT_WIDTH, 11, width of shared setup/gap/timeout counter; must hold max of the three cycle parameters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester burst request (level).
- len  in  2*LEN_WIDTH  per-requester byte count minus one; [LEN_WIDTH-1:0] = requester 0.
- tx_data  in  16  per-requester next tx byte; [7:0] = requester 0.
- tx_ready  out  2  one-cycle pulse: granted requester's tx byte sampled.
- rx_data  out  8  last received byte, shared.
- rx_valid  out  2  one-cycle pulse: rx_data valid for that requester.
- done  out  2  one-cycle pulse: burst completed normally.
- err  out  2  one-cycle pulse: burst aborted by timeout.
- grant  out  2  one-hot owner, held from SETUP through GAP.
- om_work_en  out  1  to master im_work_en.
- om_tx_data  out  8  to master im_data.
- im_rx_data  in  8  from master om_data.
- im_send_finish  in  1  master send-finish pulse.
- im_receive_finish  in  1  master receive-finish pulse.
- om_cs_n  out  1  SPI chip select, active low.

Behaviour:
- Reset values:
  - grant=0, om_work_en=0, om_cs_n=1, om_tx_data=0, rx_data=0.
  - All pulse outputs 0. State IDLE. RR pointer favours requester 0.
- IDLE:
  - If any req is high, grant it. If both are high, grant the one not granted last.
  - Latch len of the winner into a length register and clear the byte counter.
  - Go to SETUP next cycle, with om_cs_n=0 from that cycle.
  - req is sampled only in IDLE; deassertion after grant is ignored and the burst completes.
- SETUP:
  - Count CS_SETUP_CYC cycles, then enter XFER.
- XFER entry cycle:
  - Register tx_data of the owner into om_tx_data, held stable for the whole byte.
  - Pulse tx_ready[owner]. The requester presents the next byte after this pulse.
  - om_work_en=1 throughout XFER. Clear sticky flags send_f and recv_f. Clear the timeout counter.
- XFER:
  - Set send_f on im_send_finish and recv_f on im_receive_finish; pulses in the same cycle count.
  - When both flags are set, or being set this cycle, go to BYTE_DONE.
  - If the timeout counter reaches TIMEOUT_CYC-1 first, go to GAP with an err pulse.
- BYTE_DONE (1 cycle):
  - om_work_en=0; this low cycle restarts the master for the next byte.
  - rx_data<=im_rx_data, with rx_valid[owner] pulsing the following cycle aligned with the new rx_data.
  - If the byte counter equals the length register, go to GAP and pulse done[owner] on GAP entry.
  - Otherwise increment the counter and return to XFER.
- GAP:
  - om_cs_n=1, om_work_en=0. Hold grant for CS_GAP_CYC cycles.
  - Then clear grant, update the RR pointer to the owner, and go to IDLE.
- Timeout abort:
  - om_work_en drops, cs_n rises, and err[owner] pulses on GAP entry.
  - No rx_valid for the aborted byte. The RR pointer is updated as normal.
- Finish pulses arriving outside XFER are ignored.
- Length register is LEN_WIDTH bits, so len=all-ones gives 2^LEN_WIDTH bytes; no wrap.
- Async reset at any point returns to reset values immediately: cs_n=1 and work_en=0 combinationally from the registers.

Decomposition:
- Shared package `spi_pkg`:
  - State encoding (IDLE, SETUP, XFER, BYTE_DONE, GAP).
  - Default cycle constants.
- Sub-module `rr_arb2`: 2-way round-robin arbiter, taking req and last-grant pointer and returning a one-hot grant (combinational plus pointer register).

Test Plan:
- req=01, len0=0, tx0=0x61, slave returns 0x62:
  - Exactly one tx_ready[0].
  - cs_n low from SETUP to GAP.
  - rx_valid[0] with rx_data=0x62, then done[0]; grant cleared after CS_GAP_CYC.
- req=10, len1=2, tx bytes 0xA1,0xA2,0xA3 supplied on each tx_ready:
  - 3 tx_ready, 3 rx_valid[1], one done[1].
  - om_work_en low exactly one cycle between bytes.
  - cs_n stays low across all bytes.
- req=11 held for three bursts:
  - Grant order 0,1,0.
  - No overlap of cs_n low periods; gap >= CS_GAP_CYC.
- Finish ordering:
  - im_receive_finish 5 cycles before im_send_finish → BYTE_DONE one cycle after the send pulse.
  - Both pulses in the same cycle → BYTE_DONE next cycle.
- Master never finishes, TIMEOUT_CYC=16:
  - err[owner] pulses after 16 XFER cycles, with no rx_valid and no done.
  - cs_n high; the next requester is then granted.
- Async reset asserted mid-XFER of a 4-byte burst:
  - Outputs go to reset values immediately.
  - After release with req=01, a fresh burst starts from byte 0.
